// File: rtl/iter_muldiv.sv
// Shared iterative MULT/MULTU/DIV/DIVU unit: one result bit per cycle on unsigned
// magnitudes, followed by a single sign-fix cycle and a one-cycle DONE pulse.
module iter_muldiv #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  input  logic            annul_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [2*DW-1:0] result_o,
  output logic            dbz_o
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [DW-1:0]   opb_q, opb_d;
  logic            is_div_q, is_div_d;
  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic [2*DW-1:0] result_q, result_d;
  logic            dbz_q, dbz_d;

  function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] x);
    return (~x) + DW'(1);
  endfunction

  function automatic logic [2*DW-1:0] neg_2dw(input logic [2*DW-1:0] x);
    return (~x) + (2*DW)'(1);
  endfunction

  logic          in_sgn, in_s1, in_s2;
  logic [DW-1:0] in_m1, in_m2;
  logic [DW:0]   mul_sum;
  logic [2*DW-1:0] mul_next;
  logic [DW:0]   div_shift, div_diff;
  logic [2*DW-1:0] div_next;
  logic [DW-1:0] fix_q, fix_r;
  logic [2*DW-1:0] fix_val;

  always_comb begin
    in_sgn = ~op_i[0];
    in_s1  = in_sgn & opdata1_i[DW-1];
    in_s2  = in_sgn & opdata2_i[DW-1];
    in_m1  = in_s1 ? neg_dw(opdata1_i) : opdata1_i;
    in_m2  = in_s2 ? neg_dw(opdata2_i) : opdata2_i;

    // Multiply: add multiplicand into the high half when the current multiplier bit is set, then shift right.
    mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, opb_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[DW-1:1]} : {1'b0, acc_q[2*DW-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    div_shift = {acc_q[2*DW-1:DW], acc_q[DW-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_next  = div_diff[DW] ? {div_shift[DW-1:0], acc_q[DW-2:0], 1'b0}
                             : {div_diff[DW-1:0],  acc_q[DW-2:0], 1'b1};

    fix_q = (s1_q ^ s2_q) ? neg_dw(acc_q[DW-1:0]) : acc_q[DW-1:0];
    fix_r = s1_q ? neg_dw(acc_q[2*DW-1:DW]) : acc_q[2*DW-1:DW];
    if (is_div_q) fix_val = {fix_r, fix_q};
    else          fix_val = (s1_q ^ s2_q) ? neg_2dw(acc_q) : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (op_i[1] && (opdata2_i == {DW{1'b0}})) begin
            result_d = {opdata1_i, {DW{1'b1}}};
            dbz_d    = 1'b1;
            state_d  = DONE;
          end else begin
            is_div_d = op_i[1];
            s1_d     = in_s1;
            s2_d     = in_s2;
            acc_d    = op_i[1] ? {{DW{1'b0}}, in_m1} : {{DW{1'b0}}, in_m2};
            opb_d    = op_i[1] ? in_m2 : in_m1;
            cnt_d    = CW'(DW);
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          result_d = fix_val;
          dbz_d    = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign ready_o  = (state_q == DONE);
  assign result_o = result_q;
  assign dbz_o    = dbz_q;

endmodule
